// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the MUL partial-product add and the DIV trial subtract.
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           cout
);

  logic [WIDTH+1:0] full;

  // For subtraction, cout=1 means no borrow (x >= y).
  assign full = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{(WIDTH+1){1'b0}}, sub};
  assign sum  = full[WIDTH:0];
  assign cout = full[WIDTH+1];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: one result bit per clock, double-width result with a done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nx;
  logic               op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0]      cnt;
  logic               accept, dz_req, last;

  logic [WIDTH:0]     as_x, as_y, as_sum;
  logic               as_sub, as_cout;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign dz_req = (op == OP_DIV) && (b == '0);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = dz_req ? DONE : RUN;
        else        state_nx = IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // MUL: acc = {partial high, remaining multiplier}; DIV: acc = {remainder, dividend/quotient}.
  always_comb begin
    if (op_q == OP_MUL) begin
      as_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      as_y   = {1'b0, a_q};
      as_sub = 1'b0;
    end else begin
      as_x   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      as_y   = {1'b0, b_q};
      as_sub = 1'b1;
    end
  end

  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (as_x),
    .y    (as_y),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_comb begin
    acc_nx = acc;
    if (op_q == OP_MUL) begin
      if (acc[0]) acc_nx = {as_sum, acc[WIDTH-1:1]};
      else        acc_nx = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      if (as_cout) acc_nx = {as_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else         acc_nx = {as_x[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      op_q     <= op;
      a_q      <= a;
      b_q      <= b;
      cnt      <= '0;
      div_zero <= 1'b0;
      acc      <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      if (dz_req) begin
        result_lo <= '1;
        result_hi <= a;
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      acc <= acc_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        result_lo <= acc_nx[WIDTH-1:0];
        result_hi <= acc_nx[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule
